// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the data-memory arbiter
package dmem_arb_pkg;

  localparam int DEF_AW     = 10;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// rtl/dmem_rr_pick.sv - combinational two-way round-robin selector
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  master_t    rr_ptr,
  output logic       valid,
  output master_t    winner
);

  always_comb begin
    valid  = |req;
    winner = M0;
    if (req == 2'b11) begin
      winner = rr_ptr;
    end else if (req[1]) begin
      winner = M1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing the data RAM between core (M0) and loader (M1)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW     = DEF_AW
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [AW-1:0]     m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t        state, state_nxt;
  master_t       rr_ptr, win_id, pick_id;
  logic          pick_valid;
  logic          lat_we, lat_err;
  logic [AW-1:0] m0_word;
  logic          m0_misaligned;
  logic          unused_m0_addr_hi;

  // Core byte address folds onto the RAM: upper bits are dropped so it wraps.
  assign m0_word           = m0_addr[AW+1:2];
  assign m0_misaligned     = |m0_addr[1:0];
  assign unused_m0_addr_hi = ^m0_addr[31:AW+2];

  dmem_rr_pick u_pick (
    .req    ({m1_req, m0_req}),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The mem_* registers double as the latched request; they are only loaded in IDLE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rr_ptr    <= M0;
      win_id    <= M0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            win_id <= pick_id;
            if (pick_id == M0) begin
              lat_we    <= m0_we;
              lat_err   <= m0_misaligned;
              mem_en    <= ~m0_misaligned;
              mem_we    <= m0_we & ~m0_misaligned;
              mem_addr  <= m0_word;
              mem_wdata <= m0_wdata;
            end else begin
              lat_we    <= m1_we;
              lat_err   <= 1'b0;
              mem_en    <= 1'b1;
              mem_we    <= m1_we;
              mem_addr  <= m1_addr;
              mem_wdata <= m1_wdata;
            end
          end
        end
        ACCESS: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
        RESP: begin
          rr_ptr <= (win_id == M0) ? M1 : M0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = '0;
    m1_ack   = 1'b0;
    m1_rdata = '0;
    if (state == RESP) begin
      if (win_id == M0) begin
        m0_ack = 1'b1;
        m0_err = lat_err;
        if (!lat_we && !lat_err) m0_rdata = mem_rdata;
      end else begin
        m1_ack = 1'b1;
        if (!lat_we) m1_rdata = mem_rdata;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter that shares the single-port synchronous data RAM between the RISC-V core data port (master 0) and the test/loader port (master 1). It accepts level requests from both masters, selects one per access with round-robin priority, drives the RAM for one cycle, and returns a one-cycle acknowledge with read data. It sits between the core's data bus (address, write data, read/write) and the data memory in the system top.

## Interface
Parameters:
- DATA_W, 32, data width of both masters and the RAM
- AW, 10, RAM word-address width (RAM depth 2**AW words)

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RESET  input  1  asynchronous, active-high reset
- m0_req  input  1  core access request, level, held until m0_ack
- m0_we  input  1  core write enable (core d_rw), 1 = write
- m0_addr  input  32  core byte address
- m0_wdata  input  DATA_W  core write data
- m0_ack  output  1  one-cycle completion pulse to core
- m0_err  output  1  valid with m0_ack; 1 = misaligned, no RAM access
- m0_rdata  output  DATA_W  read data, valid with m0_ack
- m1_req, m1_we  input  1  loader request / write enable, same rules as m0
- m1_addr  input  AW  loader word address
- m1_wdata  input  DATA_W  loader write data
- m1_ack  output  1  one-cycle completion pulse to loader
- m1_rdata  output  DATA_W  read data, valid with m1_ack
- mem_en  output  1  RAM enable
- mem_we  output  1  RAM write enable
- mem_addr  output  AW  RAM word address
- mem_wdata  output  DATA_W  RAM write data
- mem_rdata  input  DATA_W  RAM read data, valid one cycle after mem_en

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if no req, stay. If one req, that master wins. If both, winner = master indicated by rr_ptr. Latch winner id, we, word address, wdata into registers; go ACCESS.
- M0 word address = m0_addr[AW+1:2]; bits above AW+1 ignored (wrap modulo RAM depth).
- M0 with m0_addr[1:0] != 0: latched as error; ACCESS keeps mem_en=0; RESP gives m0_ack=1, m0_err=1, m0_rdata=0.
- ACCESS: mem_en=1, mem_we/addr/wdata from latched registers; go RESP.
- RESP: winner's ack=1; for reads winner's rdata = mem_rdata; for writes rdata = 0. rr_ptr set to the non-winner; go IDLE.
- Non-winner's ack and rdata stay 0. rr_ptr changes only on a grant.
- Master inputs are sampled only in IDLE; changes during ACCESS/RESP are ignored.
- Master must drop req on the edge where it sees ack; a req still high in IDLE starts a new access.

## Timing
- Reset: state=IDLE, rr_ptr=0 (M0 favoured), mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, m0_ack=m1_ack=0, m0_err=0, both rdata=0.
- Latency: req sampled at edge k (IDLE) -> mem_en high in cycle k+1 -> ack high in cycle k+2. Throughput 1 access / 3 cycles.
- mem_* outputs are registered; acks and rdata are decoded from RESP state and latched winner, no combinational path from req to ack.
- Simultaneous requests: strict alternation while both stay asserted (M0, M1, M0, ...).
- RESET during ACCESS/RESP: aborts immediately, no ack; a write already strobed in ACCESS may have reached the RAM.

## Structure
- Package dmem_arb_pkg: state enum (IDLE, ACCESS, RESP), master id typedef (M0=0, M1=1), default AW/DATA_W constants.
- Sub-module dmem_rr_pick: combinational 2-way round-robin selector (req[1:0], rr_ptr -> valid, winner). FSM and datapath in dmem_arbiter.

## Test plan
- M0 write 0xDEADBEEF to byte addr 0x10, then read 0x10 -> mem_addr=4 on both, m0_ack at k+2, m0_rdata=0xDEADBEEF, m0_err=0.
- M1 write 0x12345678 to word 7, M0 reads byte addr 0x1C -> m0_rdata=0x12345678.
- Both req held continuously from reset for 6 grants -> order M0,M1,M0,M1,M0,M1; never both acks in same cycle.
- M0 read at byte addr 0x13 -> mem_en stays 0, m0_ack=1 with m0_err=1, m0_rdata=0.
- M0 byte addr 0x1000 with AW=10 -> mem_addr=0 (wrap).
- RESET asserted in ACCESS cycle -> next cycle all outputs at reset values, no ack; after release rr_ptr=0 and M0 wins a simultaneous request.
